bridge_demux: RTL

Single-master to four-slave bus bridge for the pipelined MIPS core: one CPU-side load/store request is decoded by address and routed to exactly one of four device ports, with the device's reply steered back. It is the distributing counterpart of the result-selection muxes: one source fans out to N destinations, with registered handshaking, wait states, and a timeout. It sits between the memory stage and the data memory / timers / I/O devices.

---
 rtl/bridge_demux_pkg.sv | 36 +++
 rtl/bridge_addr_decode.sv | 21 ++
 rtl/bridge_demux.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bridge_demux_pkg.sv
// Shared definitions for the CPU-to-device bus bridge:
// address map, port indices, FSM encoding and defaults.
package bridge_demux_pkg;

  localparam int NPORT    = 4;
  localparam int PORT_DM  = 0;
  localparam int PORT_TC0 = 1;
  localparam int PORT_TC1 = 2;
  localparam int PORT_IO  = 3;

  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7F00;
  localparam logic [31:0] TC0_LIMIT = 32'h0000_7F0B;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7F10;
  localparam logic [31:0] TC1_LIMIT = 32'h0000_7F1B;
  localparam logic [31:0] IO_BASE   = 32'h0000_7F20;
  localparam logic [31:0] IO_LIMIT  = 32'h0000_7F3F;

  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  function automatic logic in_range(
    input logic [31:0] a,
    input logic [31:0] lo,
    input logic [31:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Address decoder: maps a byte address onto the
// one-hot device select and a mapped/unmapped flag.
module bridge_addr_decode
  import bridge_demux_pkg::*;
(
  input  logic [31:0] addr,
  output logic [3:0]  sel,
  output logic        hit
);

  // Windows are disjoint, so at most one bit is set
  always_comb begin
    sel           = '0;
    sel[PORT_DM]  = in_range(addr, DM_BASE, DM_LIMIT);
    sel[PORT_TC0] = in_range(addr, TC0_BASE, TC0_LIMIT);
    sel[PORT_TC1] = in_range(addr, TC1_BASE, TC1_LIMIT);
    sel[PORT_IO]  = in_range(addr, IO_BASE, IO_LIMIT);
    hit           = |sel;
  end

endmodule

// File: rtl/bridge_demux.sv
// Single-master to four-device bus bridge with
// registered handshake, wait states and timeout.
module bridge_demux
  import bridge_demux_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [31:0]     req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [3:0]      req_be,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_err,
  output logic [3:0]      dev_sel,
  output logic            dev_we,
  output logic [31:0]     dev_addr,
  output logic [DW-1:0]   dev_wdata,
  output logic [3:0]      dev_be,
  input  logic [3:0]      dev_ready,
  input  logic [4*DW-1:0] dev_rdata
);

  state_t        state;
  logic [7:0]    cnt;
  logic [3:0]    dec_sel;
  logic          dec_hit;
  logic          req_ok;
  logic          dev_done;
  logic          timed_out;
  logic [DW-1:0] sel_rdata;

  bridge_addr_decode u_dec (
    .addr (req_addr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  assign req_ok    = dec_hit && (req_addr[1:0] == 2'b00);
  assign dev_done  = |(dev_sel & dev_ready);
  assign timed_out = (cnt == 8'(TIMEOUT));

  // Pick the read data of whichever port is selected
  always_comb begin
    sel_rdata = '0;
    unique case (1'b1)
      dev_sel[PORT_DM]:  sel_rdata = dev_rdata[PORT_DM*DW +: DW];
      dev_sel[PORT_TC0]: sel_rdata = dev_rdata[PORT_TC0*DW +: DW];
      dev_sel[PORT_TC1]: sel_rdata = dev_rdata[PORT_TC1*DW +: DW];
      dev_sel[PORT_IO]:  sel_rdata = dev_rdata[PORT_IO*DW +: DW];
      default:           sel_rdata = '0;
    endcase
  end

  // Request/access/response sequencer; all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      dev_sel    <= '0;
      dev_we     <= 1'b0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
      dev_be     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            if (req_ok) begin
              state     <= ACCESS;
              dev_sel   <= dec_sel;
              dev_we    <= req_we;
              dev_addr  <= req_addr;
              dev_wdata <= req_wdata;
              dev_be    <= req_be;
            end else begin
              // Bad address never reaches a device
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          if (dev_done) begin
            state      <= RESP;
            dev_sel    <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= dev_we ? '0 : sel_rdata;
          end else if (timed_out) begin
            state      <= RESP;
            dev_sel    <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
